// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA timing receiver.
// The XGA totals give monitors a reference to compare the measured h_total/v_total against.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } t_rx_state;

  localparam int CW_DEF      = 12;
  localparam int H_TOTAL_XGA = 1344;
  localparam int V_TOTAL_XGA = 806;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises one raw sync input into clk, normalises polarity (active = 1)
// and flags its leading edge. `rise` is combinational from flops only.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise
);

  localparam logic [SYNC_STAGES-1:0] IDLE_PIN = {SYNC_STAGES{ACT_LOW}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   norm;

  assign norm = sync_q[SYNC_STAGES-1] ^ ACT_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the chain resets to the idle pin level, so leaving reset with an
      // inactive pin cannot fake a leading edge.
      sync_q  <= IDLE_PIN;
      level_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value; blocking would collapse the chain into one flop.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_in};
      level_q <= norm;
    end
  end

  assign level = level_q;
  assign rise  = norm & ~level_q;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel/line counters from external Hsync/Vsync,
// measures line and frame length, and declares lock once they repeat.
module vga_timing_rx
  import vga_rx_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter bit HS_ACT_LOW  = 1'b1,
  parameter bit VS_ACT_LOW  = 1'b1,
  parameter int LOCK_FRAMES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic          locked,
  output logic          err
);

  localparam int            MW         = $clog2(LOCK_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);

  logic hs_rise, vs_rise;
  logic hs_level, vs_level;
  logic unused_levels;

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic [CW-1:0] h_meas_q, h_meas_d;
  logic [CW-1:0] v_meas_q, v_meas_d;
  logic          line_start_q, frame_start_q;

  t_rx_state     state_q, state_d;
  logic [CW-1:0] ref_h_q, ref_h_d;
  logic [CW-1:0] ref_v_q, ref_v_d;
  logic [CW-1:0] h_total_q, h_total_d;
  logic [CW-1:0] v_total_q, v_total_d;
  logic [MW-1:0] match_q, match_d;
  logic          bad_q, bad_d;
  logic          timeout;
  logic          reload;
  logic          err_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .ACT_LOW    (HS_ACT_LOW)
  ) u_hs_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (hs_in),
    .level(hs_level),
    .rise (hs_rise)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .ACT_LOW    (VS_ACT_LOW)
  ) u_vs_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (vs_in),
    .level(vs_level),
    .rise (vs_rise)
  );

  // Synced sync levels are kept for probing; timing is derived from the edges alone.
  assign unused_levels = hs_level ^ vs_level;

  // Counters and measurements advance on the same edge that raises the
  // line_start/frame_start pulses, so the pulse cycle shows count 0 and the
  // freshly captured length of the line/frame that just ended.
  always_comb begin
    hcount_d = (hcount_q == CNT_MAX) ? hcount_q : hcount_q + 1'b1;
    if (hs_rise) hcount_d = '0;

    vcount_d = vcount_q;
    if (vs_rise) begin
      vcount_d = '0;
    end else if (hs_rise && vcount_q != CNT_MAX) begin
      vcount_d = vcount_q + 1'b1;
    end

    h_meas_d = hs_rise ? hcount_q + 1'b1 : h_meas_q;
    v_meas_d = vs_rise ? vcount_q + 1'b1 : v_meas_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      line_start_q  <= hs_rise;
      frame_start_q <= vs_rise;
    end
  end

  assign timeout = (hcount_q == CNT_MAX) || (vcount_q == CNT_MAX);

  always_comb begin
    // NOTE: every variable gets its hold value first; a path that forgets one
    // would otherwise infer a latch.
    state_d   = state_q;
    ref_h_d   = ref_h_q;
    ref_v_d   = ref_v_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    match_d   = match_q;
    bad_d     = bad_q;
    reload    = 1'b0;
    err_d     = 1'b0;

    if (timeout) begin
      // err only fires when leaving LOCKED, so a held-off source reports once.
      state_d = SEARCH;
      err_d   = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (frame_start_q) begin
            state_d = MEASURE;
            reload  = 1'b1;
          end
        end
        MEASURE: begin
          if (frame_start_q) begin
            if (!bad_q && v_meas_q == ref_v_q) begin
              match_d = match_q + 1'b1;
              if (match_d == MATCH_LAST) begin
                state_d   = LOCKED;
                h_total_d = ref_h_q;
                v_total_d = ref_v_q;
              end
            end else begin
              reload = 1'b1;
            end
          end else if (line_start_q && h_meas_q != ref_h_q) begin
            bad_d = 1'b1;
          end
        end
        LOCKED: begin
          if ((line_start_q && h_meas_q != h_total_q) ||
              (frame_start_q && v_meas_q != v_total_q)) begin
            state_d = MEASURE;
            err_d   = 1'b1;
            reload  = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (reload) begin
      ref_h_d = h_meas_q;
      ref_v_d = v_meas_q;
      match_d = '0;
      bad_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      ref_h_q   <= '0;
      ref_v_q   <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      match_q   <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_h_q   <= ref_h_d;
      ref_v_q   <= ref_v_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      match_q   <= match_d;
      bad_q     <= bad_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_d;

endmodule
